// File: rtl/multicycle_ctrl_if.sv
// Memory request/acknowledge port between the main control FSM and the memory.
// master = control FSM, slave = memory side.
interface multicycle_ctrl_if;
  logic o_mem_req;
  logic o_mem_we;
  logic o_addr_sel;
  logic i_mem_ack;

  modport master (output o_mem_req, output o_mem_we, output o_addr_sel, input i_mem_ack);
  modport slave  (input o_mem_req, input o_mem_we, input o_addr_sel, output i_mem_ack);
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode, execute,
// memory and writeback, with an ack timeout and sticky fault reporting.
module multicycle_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [6:0]               i_opcode,
  input  logic [2:0]               i_funct3,
  input  logic                     i_zero,
  multicycle_ctrl_if.master        mem,
  output logic                     o_ir_write,
  output logic                     o_mdr_write,
  output logic                     o_pc_write,
  output logic                     o_pc_src,
  output logic [1:0]               o_alu_src_a,
  output logic [1:0]               o_alu_src_b,
  output logic [1:0]               o_alu_op,
  output logic                     o_reg_write,
  output logic                     o_wb_sel,
  output logic                     o_retire,
  output logic [1:0]               o_fault,
  output logic [3:0]               o_state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    ALU_WB   = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    MEM_WB   = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] fault_q, fault_d;
  logic       timeout_hit;
  logic       flt_go;
  logic [1:0] flt_code;

  // Count value in the current cycle is (request cycles so far - 1); the last allowed cycle times out.
  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      fault_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = 8'd0;
    fault_d        = fault_q;
    flt_go         = 1'b0;
    flt_code       = 2'b00;
    mem.o_mem_req  = 1'b0;
    mem.o_mem_we   = 1'b0;
    mem.o_addr_sel = 1'b0;
    o_ir_write     = 1'b0;
    o_mdr_write    = 1'b0;
    o_pc_write     = 1'b0;
    o_pc_src       = 1'b0;
    o_alu_src_a    = 2'd0;
    o_alu_src_b    = 2'd0;
    o_alu_op       = 2'b00;
    o_reg_write    = 1'b0;
    o_wb_sel       = 1'b0;
    o_retire       = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        mem.o_mem_req = 1'b1;
        o_alu_src_b   = 2'd2;
        if (mem.i_mem_ack) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          state_d    = DECODE;
        end else if (timeout_hit) begin
          flt_go   = 1'b1;
          flt_code = 2'b10;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      DECODE: begin
        o_alu_src_a = 2'd1;
        o_alu_src_b = 2'd1;
        case (i_opcode)
          OP_R:               state_d = EXEC_R;
          OP_I:               state_d = EXEC_I;
          OP_LOAD, OP_STORE:  state_d = MEM_ADDR;
          OP_BRANCH: begin
            if (i_funct3 == 3'b000 || i_funct3 == 3'b001) begin
              state_d = BRANCH;
            end else begin
              flt_go   = 1'b1;
              flt_code = 2'b11;
            end
          end
          default: begin
            flt_go   = 1'b1;
            flt_code = 2'b01;
          end
        endcase
      end

      EXEC_R: begin
        o_alu_src_a = 2'd2;
        o_alu_op    = 2'b10;
        state_d     = ALU_WB;
      end

      EXEC_I: begin
        o_alu_src_a = 2'd2;
        o_alu_src_b = 2'd1;
        o_alu_op    = 2'b11;
        state_d     = ALU_WB;
      end

      ALU_WB: begin
        o_reg_write = 1'b1;
        o_retire    = 1'b1;
        state_d     = FETCH;
      end

      MEM_ADDR: begin
        o_alu_src_a = 2'd2;
        o_alu_src_b = 2'd1;
        state_d     = (i_opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      end

      MEM_RD, MEM_WR: begin
        mem.o_mem_req  = 1'b1;
        mem.o_mem_we   = (state_q == MEM_WR);
        mem.o_addr_sel = 1'b1;
        if (mem.i_mem_ack) begin
          if (state_q == MEM_RD) begin
            o_mdr_write = 1'b1;
            state_d     = MEM_WB;
          end else begin
            o_retire = 1'b1;
            state_d  = FETCH;
          end
        end else if (timeout_hit) begin
          flt_go   = 1'b1;
          flt_code = 2'b10;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      MEM_WB: begin
        o_reg_write = 1'b1;
        o_wb_sel    = 1'b1;
        o_retire    = 1'b1;
        state_d     = FETCH;
      end

      BRANCH: begin
        o_alu_src_a = 2'd2;
        o_alu_op    = 2'b01;
        o_retire    = 1'b1;
        // funct3 000 = BEQ, 001 = BNE; anything else was trapped in DECODE
        if ((i_funct3 == 3'b000) ? i_zero : ~i_zero) begin
          o_pc_write = 1'b1;
          o_pc_src   = 1'b1;
        end
        state_d = FETCH;
      end

      HALT: state_d = HALT;

      default: state_d = IDLE;
    endcase

    if (flt_go) begin
      state_d = HALT;
      if (fault_q == 2'b00) fault_d = flt_code;
    end
  end

  assign o_fault = fault_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with ACK_TIMEOUT=4; each step drives inputs just
// after a rising edge and checks outputs 1 ns later.
module tb_multicycle_ctrl;
  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [6:0] i_opcode;
  logic [2:0] i_funct3;
  logic       i_zero;
  logic       o_ir_write, o_mdr_write, o_pc_write, o_pc_src;
  logic [1:0] o_alu_src_a, o_alu_src_b, o_alu_op;
  logic       o_reg_write, o_wb_sel, o_retire;
  logic [1:0] o_fault;
  logic [3:0] o_state;

  int checks   = 0;
  int failures = 0;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(.ACK_TIMEOUT(4)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_opcode    (i_opcode),
    .i_funct3    (i_funct3),
    .i_zero      (i_zero),
    .mem         (mif),
    .o_ir_write  (o_ir_write),
    .o_mdr_write (o_mdr_write),
    .o_pc_write  (o_pc_write),
    .o_pc_src    (o_pc_src),
    .o_alu_src_a (o_alu_src_a),
    .o_alu_src_b (o_alu_src_b),
    .o_alu_op    (o_alu_op),
    .o_reg_write (o_reg_write),
    .o_wb_sel    (o_wb_sel),
    .o_retire    (o_retire),
    .o_fault     (o_fault),
    .o_state     (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_state", {4'd0, o_state}, 8'd0);
    chk("rst_fault", {6'd0, o_fault}, 8'd0);
    chk("rst_req", {7'd0, mif.o_mem_req}, 8'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_opcode = 7'd0; i_funct3 = 3'd0; i_zero = 1'b0; mif.i_mem_ack = 1'b0;
    #2;
    chk("por_state", {4'd0, o_state}, 8'd0);
    chk("por_fault", {6'd0, o_fault}, 8'd0);
    chk("por_req", {7'd0, mif.o_mem_req}, 8'd0);
    chk("por_ctrl", {o_ir_write, o_pc_write, o_reg_write, o_retire, o_alu_src_b, o_alu_op}, 8'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // R-type, zero-wait memory: 1,2,3,5,1
    nxt(); mif.i_mem_ack = 1'b1; i_opcode = 7'b0110011; #1;
    chk("r_fetch_state", {4'd0, o_state}, 8'd1);
    chk("r_fetch_ctl", {mif.o_mem_req, mif.o_addr_sel, o_ir_write, o_pc_write, o_pc_src, o_alu_src_b, 1'b0}, 8'b1011_0100);
    nxt(); #1;
    chk("r_dec_state", {4'd0, o_state}, 8'd2);
    chk("r_dec_ctl", {mif.o_mem_req, o_ir_write, o_alu_src_a, o_alu_src_b, o_alu_op}, 8'b0001_0100);
    nxt(); #1;
    chk("r_exec_state", {4'd0, o_state}, 8'd3);
    chk("r_exec_ctl", {o_alu_src_a, o_alu_src_b, o_alu_op, o_reg_write, o_retire}, 8'b1000_1000);
    nxt(); #1;
    chk("r_wb_state", {4'd0, o_state}, 8'd5);
    chk("r_wb_ctl", {5'd0, o_reg_write, o_wb_sel, o_retire}, 8'b0000_0101);

    // LOAD with ack on the third request cycle of each access
    nxt(); mif.i_mem_ack = 1'b0; i_opcode = 7'b0000011; #1;
    chk("ld_f1", {4'd0, o_state}, 8'd1);
    chk("ld_f1_ctl", {5'd0, mif.o_mem_req, mif.o_addr_sel, o_ir_write}, 8'b0000_0100);
    nxt(); #1;
    chk("ld_f2_req", {6'd0, mif.o_mem_req, mif.o_addr_sel}, 8'b10);
    nxt(); mif.i_mem_ack = 1'b1; #1;
    chk("ld_f3_ctl", {5'd0, mif.o_mem_req, mif.o_addr_sel, o_ir_write}, 8'b0000_0101);
    nxt(); mif.i_mem_ack = 1'b0; #1;
    chk("ld_dec", {4'd0, o_state}, 8'd2);
    nxt(); #1;
    chk("ld_addr_state", {4'd0, o_state}, 8'd6);
    chk("ld_addr_ctl", {2'd0, o_alu_src_a, o_alu_src_b, o_alu_op}, 8'b0010_0100);
    nxt(); #1;
    chk("ld_rd1", {3'd0, o_state, mif.o_mem_req}, {3'd0, 4'd7, 1'b1});
    chk("ld_rd1_ctl", {4'd0, mif.o_mem_we, mif.o_addr_sel, o_mdr_write, o_reg_write}, 8'b0000_0100);
    nxt(); #1;
    chk("ld_rd2", {6'd0, mif.o_mem_req, mif.o_addr_sel}, 8'b11);
    nxt(); mif.i_mem_ack = 1'b1; #1;
    chk("ld_rd3_mdr", {6'd0, mif.o_addr_sel, o_mdr_write}, 8'b11);
    nxt(); mif.i_mem_ack = 1'b0; #1;
    chk("ld_wb_state", {4'd0, o_state}, 8'd8);
    chk("ld_wb_ctl", {4'd0, o_mdr_write, o_reg_write, o_wb_sel, o_retire}, 8'b0000_0111);

    // STORE, zero-wait
    nxt(); mif.i_mem_ack = 1'b1; i_opcode = 7'b0100011; #1;
    chk("st_fetch", {4'd0, o_state}, 8'd1);
    nxt(); nxt(); #1;
    chk("st_addr", {4'd0, o_state}, 8'd6);
    nxt(); #1;
    chk("st_wr_state", {4'd0, o_state}, 8'd9);
    chk("st_wr_ctl", {4'd0, mif.o_mem_req, mif.o_mem_we, mif.o_addr_sel, o_retire}, 8'b0000_1111);

    // BEQ taken
    nxt(); i_opcode = 7'b1100011; i_funct3 = 3'b000; i_zero = 1'b1; #1;
    chk("beq_fetch", {4'd0, o_state}, 8'd1);
    nxt(); nxt(); #1;
    chk("beq_state", {4'd0, o_state}, 8'd10);
    chk("beq_ctl", {o_alu_src_a, o_alu_op, 1'b0, o_pc_write, o_pc_src, o_retire}, 8'b1001_0111);

    // BNE with zero=1 (not taken), then zero=0 (taken)
    nxt(); i_funct3 = 3'b001; #1;
    nxt(); nxt(); #1;
    chk("bne_state", {4'd0, o_state}, 8'd10);
    chk("bne_nt_ctl", {2'd0, o_alu_op, 1'b0, o_pc_write, o_pc_src, o_retire}, 8'b0001_0001);
    i_zero = 1'b0; #1;
    chk("bne_t_ctl", {5'd0, o_pc_write, o_pc_src, o_retire}, 8'b0000_0111);

    // I-type with ack exactly on the 4th request cycle: ack wins over timeout
    nxt(); mif.i_mem_ack = 1'b0; i_opcode = 7'b0010011; #1;
    nxt(); nxt(); nxt(); mif.i_mem_ack = 1'b1; #1;
    chk("to4_ack_cycle", {3'd0, o_state, o_ir_write}, {3'd0, 4'd1, 1'b1});
    nxt(); mif.i_mem_ack = 1'b0; #1;
    chk("to4_dec", {2'd0, o_fault, o_state}, {2'd0, 2'b00, 4'd2});
    nxt(); #1;
    chk("exec_i_ctl", {o_state, o_alu_src_b, o_alu_op}, {4'd4, 2'd1, 2'b11});
    nxt(); #1;
    chk("exec_i_wb", {4'd0, o_state}, 8'd5);

    // Branch with unsupported funct3
    nxt(); mif.i_mem_ack = 1'b1; i_opcode = 7'b1100011; i_funct3 = 3'b100; #1;
    nxt(); #1;
    chk("bad_f3_dec", {2'd0, o_fault, o_state}, {2'd0, 2'b00, 4'd2});
    nxt(); #1;
    chk("bad_f3_halt", {2'd0, o_fault, o_state}, {2'd0, 2'b11, 4'd11});
    nxt(); nxt(); #1;
    chk("bad_f3_hold", {1'b0, mif.o_mem_req, o_retire, o_pc_write, o_state}, {4'd0, 4'd11});

    // Timeout: ack never arrives
    do_reset();
    nxt(); mif.i_mem_ack = 1'b0; i_opcode = 7'b0110011; i_funct3 = 3'b000; #1;
    chk("to_c1", {3'd0, o_state, mif.o_mem_req}, {3'd0, 4'd1, 1'b1});
    nxt(); nxt(); nxt(); #1;
    chk("to_c4", {1'b0, o_fault, o_state, mif.o_mem_req}, {1'b0, 2'b00, 4'd1, 1'b1});
    nxt(); #1;
    chk("to_halt", {1'b0, o_fault, o_state, mif.o_mem_req}, {1'b0, 2'b10, 4'd11, 1'b0});

    // Illegal opcode (JAL)
    do_reset();
    nxt(); mif.i_mem_ack = 1'b1; i_opcode = 7'b1101111; #1;
    nxt(); nxt(); #1;
    chk("ill_halt", {2'd0, o_fault, o_state}, {2'd0, 2'b01, 4'd11});
    nxt(); nxt(); #1;
    chk("ill_noreq", {1'b0, o_fault, o_state, mif.o_mem_req}, {1'b0, 2'b01, 4'd11, 1'b0});

    // Reset asserted in the middle of MEM_WR
    do_reset();
    nxt(); i_opcode = 7'b0100011; #1;
    nxt(); nxt(); nxt(); mif.i_mem_ack = 1'b0; #1;
    chk("mw_state", {2'd0, o_state, mif.o_mem_req, mif.o_mem_we}, {2'd0, 4'd9, 2'b11});
    #2 i_rst_n = 1'b0;
    #1;
    chk("mw_rst", {1'b0, o_fault, o_state, mif.o_mem_req}, 8'd0);
    chk("mw_rst_we", {6'd0, mif.o_mem_we, o_retire}, 8'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    nxt(); #1;
    chk("mw_restart", {4'd0, o_state}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
